// File: rtl/dac_pkg.sv
// Shared definitions for the interleaved DAC output stage: sample width,
// packed-word field positions, FSM state encoding and counter width.
package dac_pkg;

   localparam int DAC_DATA_WIDTH     = 10;
   localparam int WORD_WIDTH         = 32;
   localparam int UNDERRUN_CNT_WIDTH = 16;

   // Field positions in bus bit numbering (bit 0 = MSB of the 32-bit word).
   localparam int CHA_MSB = 0;
   localparam int CHB_MSB = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SLOT_A = 2'd1,
      SLOT_B = 2'd2
   } dac_state_e;

   // Maps a bus bit number (0 = MSB) to the conventional [31:0] index.
   function automatic int plb_to_lsb0(input int plb_bit);
      return WORD_WIDTH - 1 - plb_bit;
   endfunction

endpackage

// File: rtl/dac_sync_fifo.sv
// Single-clock FIFO for packed sample pairs. Read data is show-ahead:
// rdata always presents the oldest stored word while the FIFO is non-empty.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module dac_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                     clk_sys,
   input  logic                     rst_b,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage array; contents are don't-care while the level says empty.
   always_ff @(posedge clk_sys) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push_ok && !pop_ok) begin
            level <= level + LW'(1);
         end else if (pop_ok && !push_ok) begin
            level <= level - LW'(1);
         end
      end
   end

endmodule

// File: rtl/dac_interleaver.sv
// Interleaved dual-channel DAC driver. Buffers packed sample pairs in a FIFO
// and plays each pair as an A slot followed by a B slot, each Rate_Div+1
// clocks long. When the FIFO runs dry at a pair boundary the held pair is
// replayed and Underrun pulses.
//
// Build option: define DAC_UNDERRUN_CNT_EN to implement the saturating
// Underrun_Cnt register; otherwise Underrun_Cnt is tied to zero.
//
// state  | meaning
// IDLE   | engine stopped, DCLKIO low, last sample held on the bus
// SLOT_A | channel A sample on the bus, DCLKIO low
// SLOT_B | channel B sample on the bus, DCLKIO high
module dac_interleaver
   import dac_pkg::*;
#(
   parameter int DATA_WIDTH = 10,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                          Bus2IP_Clk,
   input  logic                          Bus2IP_Reset_n,
   input  logic                          Enable,
   input  logic                          Format,
   input  logic [DIV_WIDTH-1:0]          Rate_Div,
   input  logic [31:0]                   S_Data,
   input  logic                          S_Valid,
   output logic                          S_Ready,
   output logic [DATA_WIDTH-1:0]         IP2DAC_Data,
   output logic                          IP2DAC_DCLKIO,
   output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level,
   output logic                          Underrun,
   output logic [UNDERRUN_CNT_WIDTH-1:0] Underrun_Cnt
);

   localparam int CHA_HI = plb_to_lsb0(CHA_MSB);
   localparam int CHB_HI = plb_to_lsb0(CHB_MSB);

   dac_state_e            state;
   dac_state_e            state_nxt;
   logic [DIV_WIDTH-1:0]  cnt;
   logic [DIV_WIDTH-1:0]  cnt_nxt;
   logic [DIV_WIDTH-1:0]  div;
   logic [DIV_WIDTH-1:0]  div_nxt;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] a_nxt;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] b_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic                  dclk_nxt;
   logic                  underrun_nxt;
   logic                  pop;

   logic [31:0]           fifo_rdata;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] head_a;
   logic [DATA_WIDTH-1:0] head_b;
   logic                  unused_bits;

   // Two's-complement input becomes offset binary by flipping the MSB.
   function automatic logic [DATA_WIDTH-1:0] to_dac(input logic [DATA_WIDTH-1:0] x,
                                                    input logic                  fmt);
      logic [DATA_WIDTH-1:0] y;
      y = x;
      if (fmt) begin
         y[DATA_WIDTH-1] = ~x[DATA_WIDTH-1];
      end
      return y;
   endfunction

   dac_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk_sys (Bus2IP_Clk),
      .rst_b   (Bus2IP_Reset_n),
      .push    (S_Valid),
      .wdata   (S_Data),
      .pop     (pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (Fifo_Level)
   );

   // Ready reflects the stored level only; a same-cycle pop does not free a slot.
   assign S_Ready = !fifo_full;

   assign head_a = to_dac(fifo_rdata[CHA_HI -: DATA_WIDTH], Format);
   assign head_b = to_dac(fifo_rdata[CHB_HI -: DATA_WIDTH], Format);

   // Padding bits of the packed word carry no information.
   assign unused_bits = ^{fifo_rdata[CHA_HI-DATA_WIDTH:CHB_HI+1],
                          fifo_rdata[CHB_HI-DATA_WIDTH:0]};

   // Next-state, slot timing and next bus value; outputs are registered below.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      div_nxt      = div;
      a_nxt        = a_q;
      b_nxt        = b_q;
      data_nxt     = IP2DAC_Data;
      dclk_nxt     = IP2DAC_DCLKIO;
      underrun_nxt = 1'b0;
      pop          = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt  = '0;
            dclk_nxt = 1'b0;
            if (Enable && !fifo_empty) begin
               pop       = 1'b1;
               state_nxt = SLOT_A;
            end
         end
         SLOT_A: begin
            if (cnt == div) begin
               cnt_nxt   = '0;
               state_nxt = SLOT_B;
               data_nxt  = b_q;
               dclk_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + DIV_WIDTH'(1);
            end
         end
         SLOT_B: begin
            if (cnt == div) begin
               cnt_nxt = '0;
               if (Enable && !fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = SLOT_A;
               end else if (Enable) begin
                  state_nxt    = SLOT_A;
                  data_nxt     = a_q;
                  dclk_nxt     = 1'b0;
                  underrun_nxt = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  dclk_nxt  = 1'b0;
               end
            end else begin
               cnt_nxt = cnt + DIV_WIDTH'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            dclk_nxt  = 1'b0;
         end
      endcase

      // A pop captures the slot length, both converted samples and starts slot A.
      if (pop) begin
         div_nxt  = Rate_Div;
         a_nxt    = head_a;
         b_nxt    = head_b;
         data_nxt = head_a;
         dclk_nxt = 1'b0;
      end
   end

   // Engine state and registered DAC-side outputs.
   always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Reset_n) begin
      if (!Bus2IP_Reset_n) begin
         state         <= IDLE;
         cnt           <= '0;
         div           <= '0;
         a_q           <= '0;
         b_q           <= '0;
         IP2DAC_Data   <= '0;
         IP2DAC_DCLKIO <= 1'b0;
         Underrun      <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         div           <= div_nxt;
         a_q           <= a_nxt;
         b_q           <= b_nxt;
         IP2DAC_Data   <= data_nxt;
         IP2DAC_DCLKIO <= dclk_nxt;
         Underrun      <= underrun_nxt;
      end
   end

`ifdef DAC_UNDERRUN_CNT_EN
   logic [UNDERRUN_CNT_WIDTH-1:0] underrun_cnt_q;

   // Saturating underrun count, cleared only by reset.
   always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Reset_n) begin
      if (!Bus2IP_Reset_n) begin
         underrun_cnt_q <= '0;
      end else if (underrun_nxt && (underrun_cnt_q != '1)) begin
         underrun_cnt_q <= underrun_cnt_q + UNDERRUN_CNT_WIDTH'(1);
      end
   end

   assign Underrun_Cnt = underrun_cnt_q;
`else
   assign Underrun_Cnt = '0;
`endif

endmodule
